mem_access_unit: RTL

//  Load/store unit between the CPU memory stage and the word-wide data ram (async read, write on posedge).

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_byte_lane.sv | 57 +++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, default widths.
package mem_access_unit_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Access size codes carried on i_req_size
    localparam logic [1:0] MEM_SZ_B   = 2'b00;
    localparam logic [1:0] MEM_SZ_H   = 2'b01;
    localparam logic [1:0] MEM_SZ_W   = 2'b10;
    localparam logic [1:0] MEM_SZ_ILL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational lane logic for a 32-bit little-endian word.
//   size_i/lane_i   access size code and byte lane (addr[1:0])
//   unsigned_i      1 = zero-extend loads, 0 = sign-extend
//   load_word_i     ram word being loaded -> load_data_o (lane-selected, extended)
//   old_word_i      current ram word, new_data_i right-justified store data
//                   -> store_word_o (old word with the addressed lane(s) replaced)
module mem_access_unit_byte_lane
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] mask;
    logic [31:0] rep;

    // Load path: pick the lane, then extend
    always_comb begin
        byte_sel    = 8'(load_word_i >> {lane_i, 3'b000});
        half_sel    = lane_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        load_data_o = load_word_i;
        case (size_i)
            MEM_SZ_B: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            MEM_SZ_H: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default:  load_data_o = load_word_i;
        endcase
    end

    // Store path: replicate new data across lanes, mask it into the old word
    always_comb begin
        mask         = 32'h0000_0000;
        rep          = 32'h0000_0000;
        store_word_o = new_data_i;
        case (size_i)
            MEM_SZ_B: begin
                mask         = 32'h0000_00FF << {lane_i, 3'b000};
                rep          = {4{new_data_i[7:0]}};
                store_word_o = (old_word_i & ~mask) | (rep & mask);
            end
            MEM_SZ_H: begin
                mask         = lane_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                rep          = {2{new_data_i[15:0]}};
                store_word_o = (old_word_i & ~mask) | (rep & mask);
            end
            default: store_word_o = new_data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU memory stage and a word-wide data ram
// (async read, write on posedge). One request in flight at a time.
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_req_* / o_req_ready             request handshake (ready only in IDLE)
//   o_resp_valid/_rdata/_err          one-cycle response pulse with registered data
//   o_ram_addr/_wdata/_we, i_ram_rdata word-wide ram port
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned RAM_ADDR_WIDTH = 7
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [1:0]                i_req_size,
    input  logic                      i_req_unsigned,
    input  logic [31:0]               i_req_addr,
    input  logic [DATA_WIDTH-1:0]     i_req_wdata,
    output logic                      o_resp_valid,
    output logic [DATA_WIDTH-1:0]     o_resp_rdata,
    output logic                      o_resp_err,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0]     o_ram_wdata,
    output logic                      o_ram_we,
    input  logic [DATA_WIDTH-1:0]     i_ram_rdata
);

    localparam int unsigned BYTE_AW = RAM_ADDR_WIDTH + 2;

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [1:0]                lane_q,  lane_d;
    logic [1:0]                size_q,  size_d;
    logic                      uns_q,   uns_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     old_q,   old_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      err_q,   err_d;

    logic                      req_err_c;
    logic [DATA_WIDTH-1:0]     load_ext_c;
    logic [DATA_WIDTH-1:0]     merged_c;

    // Misalignment, illegal size or address outside the ram's byte span
    assign req_err_c = (i_req_size == MEM_SZ_ILL)
                     | ((i_req_size == MEM_SZ_H) & i_req_addr[0])
                     | ((i_req_size == MEM_SZ_W) & (i_req_addr[1:0] != 2'b00))
                     | (|i_req_addr[31:BYTE_AW]);

    mem_access_unit_byte_lane u_lane (
        .size_i       (size_q),
        .lane_i       (lane_q),
        .unsigned_i   (uns_q),
        .load_word_i  (i_ram_rdata),
        .old_word_i   (old_q),
        .new_data_i   (wdata_q),
        .load_data_o  (load_ext_c),
        .store_word_o (merged_c)
    );

    // State and latch registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; response registers only change on entry to RESP
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    waddr_d = i_req_addr[BYTE_AW-1:2];
                    lane_d  = i_req_addr[1:0];
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    wdata_d = i_req_wdata;
                    if (req_err_c) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!i_req_we) begin
                        state_d = ST_LOAD;
                    end else if (i_req_size == MEM_SZ_W) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = load_ext_c;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_READ: begin
                old_d   = i_ram_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registers so reset clears them immediately
    assign o_req_ready  = (state_q == ST_IDLE);
    assign o_resp_valid = (state_q == ST_RESP);
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;
    assign o_ram_addr   = waddr_q;
    assign o_ram_wdata  = merged_c;
    assign o_ram_we     = (state_q == ST_WRITE);

endmodule
